rv32_run_ctrl: RTL and testbench
================================

# rv32_run_ctrl

Synthesisable run controller that sequences the RV32 core through reset, execution and termination, replacing hand-timed reset pulses and fixed-delay `$finish` in benches. Sits between the bench/FPGA top and `RV32_top`: drives the core's reset, snoops data-memory writes for a `tohost` store, counts cycles and retired instructions, and flags pass/fail/timeout. Parametrised in data width, reset length, timeout and counter width.

## Interface
- `XLEN`, 32, data/address width of the snooped memory port
- `RST_CYCLES`, 3, cycles `core_rst` is held low after a start (≥1)
- `TIMEOUT`, 4096, RUN cycles before declaring timeout (≥2)
- `CNT_W`, 32, width of cycle and instret counters
- `TOHOST_ADDR`, 32'h0000_1000, word address whose store ends the run

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset of this block
- `start`  in  1  one-cycle request to begin/restart a run
- `abort`  in  1  force return to IDLE
- `dmem_we`  in  1  core data-memory write enable
- `dmem_addr`  in  XLEN  core data-memory address
- `dmem_wdata`  in  XLEN  core data-memory write data
- `instr_retired`  in  1  one pulse per retired instruction
- `core_rst`  out  1  active-low reset to `RV32_top`, registered
- `running`  out  1  state is RUN
- `done`  out  1  state is DONE
- `pass`, `fail`, `timeout`  out  1 each  termination cause, valid while `done`
- `exit_code`  out  XLEN  `dmem_wdata >> 1` captured at tohost store
- `cycle_count`  out  CNT_W  cycles spent in RUN
- `instret_count`  out  CNT_W  retired instructions in RUN

## Operation
- States: IDLE, RESET, RUN, DONE.
- IDLE: `core_rst`=0. `start` → RESET, clears counters, flags, `exit_code`, loads reset counter with `RST_CYCLES-1`.
- RESET: `core_rst`=0, decrement; at 0 → RUN.
- RUN: `core_rst`=1. `cycle_count` +1 each cycle; `instret_count` +1 per `instr_retired`. Counters saturate at all-ones.
- tohost: `dmem_we` && `dmem_addr==TOHOST_ADDR` in RUN → DONE; `pass`=(wdata==1), `fail`=!pass, `exit_code`=wdata>>1.
- Timeout: `cycle_count==TIMEOUT-1` with no tohost store → DONE, `timeout`=1, pass=fail=0.
- Same-cycle tohost and timeout: tohost wins, `timeout`=0.
- DONE: `core_rst`=0 (core frozen), counters and flags held. `start` → RESET (restart).
- `abort` in any state → IDLE, flags cleared, counters held; abort beats start.
- `start` in RESET or RUN ignored.
- Stores outside RUN ignored; `instr_retired` outside RUN not counted.

## Timing
- Async `rst` low: state IDLE, `core_rst`=0, all flags 0, `exit_code`=0, counters 0, immediately.
- `start` at edge N → RESET from N+1; `core_rst` low through RESET_CYCLES cycles; rises at the edge entering RUN (N+1+RST_CYCLES).
- Termination store sampled at edge M → `done`, cause flags, `exit_code` valid after M; `core_rst` low after M. `cycle_count` includes cycle M.
- Flag outputs registered; `running`/`done` decoded from state register.
- `rst` asserted mid-RUN: everything returns to reset values; no partial capture.

## Structure
- Package `rv32_sim_pkg`: state encodings, default `TOHOST_ADDR`, pass code (1), exit-code shift.
- Sub-module `rv32_sat_counter` (width param, clear, enable, saturation), instantiated twice.
- Intended bench: `RV32_tb` successor instantiating `rv32_run_ctrl` + `RV32_top`, ending on `done`.

## Test plan
- `rst` low 2 cycles, release, `start` pulse, RST_CYCLES=3 → `core_rst` low exactly 3 cycles after start, then `running`=1.
- Store 32'h1 to 32'h1000 at RUN cycle 20 → `done`, `pass`=1, `exit_code`=0, `cycle_count`=20.
- Store 32'h7 to 32'h1000 → `fail`=1, `exit_code`=3; store 32'h1 to 32'h1004 earlier → ignored.
- TIMEOUT=16, no store → `timeout`=1 after 16 RUN cycles; store on cycle 16 → `pass`, `timeout`=0.
- 10 `instr_retired` pulses in RUN, 2 in RESET → `instret_count`=10; CNT_W=4, TIMEOUT=64 → `cycle_count` sticks at 15.
- `rst` low mid-RUN → all outputs reset; `abort`+`start` same cycle in DONE → IDLE; `start` in DONE → restart with cleared counters.

Source files
------------

// File: rtl/rv32_sim_pkg.sv
// ---------------------------------------------------------------------------
// rv32_sim_pkg
// Shared definitions for the RV32 run controller: controller state
// encodings, the default tohost word address, the value a passing test
// stores to tohost, and the shift that turns the stored word into an
// exit code.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32_sim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

    // Riscv-tests convention: tohost <- (exit_code << 1) | 1, so a plain 1 is pass
    localparam int unsigned PASS_CODE  = 1;
    localparam int unsigned EXIT_SHIFT = 1;

endpackage

// File: rtl/rv32_sat_counter.sv
// ---------------------------------------------------------------------------
// rv32_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset (count -> 0)
//   i_clr    synchronous clear, has priority over i_en
//   i_en     count enable
//   o_count  current count value
// ---------------------------------------------------------------------------
module rv32_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_sat;

    assign w_sat = &r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rv32_run_ctrl.sv
// ---------------------------------------------------------------------------
// rv32_run_ctrl
// Sequences an RV32 core through reset, execution and termination. Holds
// the core in reset for RST_CYCLES after a start, lets it run while counting
// cycles and retired instructions, and stops it on a store to TOHOST_ADDR
// (pass/fail + exit code) or after TIMEOUT run cycles.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_abort        start/restart request, force back to idle
//   i_dmem_we/addr/wdata    snooped core data-memory write port
//   i_instr_retired         one pulse per retired instruction
//   o_core_rst              registered active-low reset to the core
//   o_running, o_done       decoded from the state register
//   o_pass/o_fail/o_timeout termination cause, valid while o_done
//   o_exit_code             stored tohost word >> 1
//   o_cycle_count           cycles spent in RUN (saturating)
//   o_instret_count         retired instructions in RUN (saturating)
// ---------------------------------------------------------------------------
module rv32_run_ctrl
    import rv32_sim_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              RST_CYCLES  = 3,
    parameter int              TIMEOUT     = 4096,
    parameter int              CNT_W       = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(DEFAULT_TOHOST_ADDR)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_dmem_we,
    input  logic [XLEN-1:0]  i_dmem_addr,
    input  logic [XLEN-1:0]  i_dmem_wdata,
    input  logic             i_instr_retired,
    output logic             o_core_rst,
    output logic             o_running,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_fail,
    output logic             o_timeout,
    output logic [XLEN-1:0]  o_exit_code,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_instret_count
);

    localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);
    localparam logic [63:0]     TO_LAST = 64'(TIMEOUT - 1);

    run_state_e       r_state;
    run_state_e       w_state_next;
    logic [RC_W-1:0]  r_rst_cnt;
    logic             r_core_rst;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic [XLEN-1:0]  r_exit_code;
    logic [CNT_W-1:0] w_cycle_count;
    logic [CNT_W-1:0] w_instret_count;
    logic             w_launch;
    logic             w_in_run;
    logic             w_tohost;
    logic             w_to_hit;

    // A start is only honoured from IDLE or DONE, and abort always beats it
    assign w_launch = i_start && !i_abort && (r_state == ST_IDLE || r_state == ST_DONE);
    // Abort freezes the counters, so an aborted RUN cycle is not counted
    assign w_in_run = (r_state == ST_RUN) && !i_abort;
    assign w_tohost = w_in_run && i_dmem_we && (i_dmem_addr == TOHOST_ADDR);
    // Compared on the pre-increment value: the TIMEOUT-th RUN cycle ends the run.
    // A counter too narrow to reach TIMEOUT-1 never times out.
    assign w_to_hit = w_in_run && (64'(w_cycle_count) == TO_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (i_abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (i_start)             w_state_next = ST_RESET;
                ST_RESET:         if (r_rst_cnt == '0)     w_state_next = ST_RUN;
                ST_RUN:           if (w_tohost || w_to_hit) w_state_next = ST_DONE;
                default:                                   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_running = (r_state == ST_RUN);
        o_done    = (r_state == ST_DONE);
    end

    // Reset countdown, core reset and termination flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_cnt   <= '0;
            r_core_rst  <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= '0;
        end else begin
            // Registered so the core sees a clean edge exactly when RUN begins
            r_core_rst <= (w_state_next == ST_RUN);

            if (w_launch) begin
                r_rst_cnt <= RC_LOAD;
            end else if (r_state == ST_RESET && r_rst_cnt != '0) begin
                r_rst_cnt <= r_rst_cnt - 1'b1;
            end

            // Exit code is cleared together with the cause flags on abort
            if (i_abort || w_launch) begin
                r_pass      <= 1'b0;
                r_fail      <= 1'b0;
                r_timeout   <= 1'b0;
                r_exit_code <= '0;
            end else if (w_tohost) begin
                // tohost has priority over a same-cycle timeout
                r_pass      <= (i_dmem_wdata == XLEN'(PASS_CODE));
                r_fail      <= (i_dmem_wdata != XLEN'(PASS_CODE));
                r_exit_code <= i_dmem_wdata >> EXIT_SHIFT;
            end else if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    rv32_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_launch),
        .i_en    (w_in_run),
        .o_count (w_cycle_count)
    );

    rv32_sat_counter #(.W(CNT_W)) u_instret_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_launch),
        .i_en    (w_in_run && i_instr_retired),
        .o_count (w_instret_count)
    );

    assign o_core_rst      = r_core_rst;
    assign o_pass          = r_pass;
    assign o_fail          = r_fail;
    assign o_timeout       = r_timeout;
    assign o_exit_code     = r_exit_code;
    assign o_cycle_count   = w_cycle_count;
    assign o_instret_count = w_instret_count;

endmodule

// File: tb/tb_rv32_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32_run_ctrl
// Three controllers with different reset lengths, timeouts and counter
// widths share one stimulus stream. A behavioural model per instance
// predicts every output each cycle; directed phases pin the model with
// hand-computed values before a randomized phase.
// ---------------------------------------------------------------------------
module tb_rv32_run_ctrl;

    localparam int PH_IDLE = 0;
    localparam int PH_RST  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DONE = 3;

    typedef struct {
        int          ph;
        int          left;   // reset cycles still to go
        longint      cyc;
        longint      ins;
        bit          pass;
        bit          fail;
        bit          to;
        logic [31:0] exitc;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        we = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        a_core_rst, a_running, a_done, a_pass, a_fail, a_to;
    logic [31:0] a_exit, a_cyc, a_ins;
    logic        b_core_rst, b_running, b_done, b_pass, b_fail, b_to;
    logic [31:0] b_exit, b_cyc, b_ins;
    logic        c_core_rst, c_running, c_done, c_pass, c_fail, c_to;
    logic [31:0] c_exit;
    logic [3:0]  c_cyc, c_ins;

    int   n_checks = 0;
    int   n_fail   = 0;
    mdl_t ma, mb, mc;

    always #5 clk = ~clk;

    rv32_run_ctrl #(.XLEN(32), .RST_CYCLES(3), .TIMEOUT(64), .CNT_W(32), .TOHOST_ADDR(32'h1000)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_dmem_we(we), .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_instr_retired(ret),
        .o_core_rst(a_core_rst), .o_running(a_running), .o_done(a_done),
        .o_pass(a_pass), .o_fail(a_fail), .o_timeout(a_to), .o_exit_code(a_exit),
        .o_cycle_count(a_cyc), .o_instret_count(a_ins)
    );

    rv32_run_ctrl #(.XLEN(32), .RST_CYCLES(1), .TIMEOUT(16), .CNT_W(32), .TOHOST_ADDR(32'h1000)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_dmem_we(we), .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_instr_retired(ret),
        .o_core_rst(b_core_rst), .o_running(b_running), .o_done(b_done),
        .o_pass(b_pass), .o_fail(b_fail), .o_timeout(b_to), .o_exit_code(b_exit),
        .o_cycle_count(b_cyc), .o_instret_count(b_ins)
    );

    rv32_run_ctrl #(.XLEN(32), .RST_CYCLES(2), .TIMEOUT(64), .CNT_W(4), .TOHOST_ADDR(32'h1000)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_dmem_we(we), .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_instr_retired(ret),
        .o_core_rst(c_core_rst), .o_running(c_running), .o_done(c_done),
        .o_pass(c_pass), .o_fail(c_fail), .o_timeout(c_to), .o_exit_code(c_exit),
        .o_cycle_count(c_cyc), .o_instret_count(c_ins)
    );

    function automatic mdl_t mreset();
        mdl_t m;
        m.ph = PH_IDLE; m.left = 0; m.cyc = 0; m.ins = 0;
        m.pass = 1'b0; m.fail = 1'b0; m.to = 1'b0; m.exitc = '0;
        return m;
    endfunction

    // One clock of the controller's rules, using the inputs present at the edge
    function automatic mdl_t mstep(mdl_t m_in, int rstc, int tmo, int cntw);
        mdl_t   m;
        longint cap;
        longint old;
        m   = m_in;
        cap = (longint'(1) << cntw) - 1;
        if (abort) begin
            m.ph = PH_IDLE; m.pass = 1'b0; m.fail = 1'b0; m.to = 1'b0; m.exitc = '0;
            return m;
        end
        case (m.ph)
            PH_IDLE, PH_DONE: begin
                if (start) begin
                    m = mreset();
                    m.ph = PH_RST;
                    m.left = rstc;
                end
            end
            PH_RST: begin
                m.left = m.left - 1;
                if (m.left == 0) m.ph = PH_RUN;
            end
            PH_RUN: begin
                old = m.cyc;
                m.cyc = (old + 1 > cap) ? cap : old + 1;
                if (ret) m.ins = (m.ins + 1 > cap) ? cap : m.ins + 1;
                if (we && addr == 32'h1000) begin
                    m.ph = PH_DONE;
                    m.pass = (wdata == 32'd1);
                    m.fail = (wdata != 32'd1);
                    m.exitc = wdata >> 1;
                end else if (old == longint'(tmo - 1)) begin
                    m.ph = PH_DONE;
                    m.to = 1'b1;
                end
            end
            default: m.ph = PH_IDLE;
        endcase
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input string t, input mdl_t m,
                            input logic cr, input logic rn, input logic dn,
                            input logic ps, input logic fl, input logic to,
                            input logic [31:0] ex, input logic [63:0] cy, input logic [63:0] ic);
        chk({t, "_core_rst"}, 64'(cr), 64'(m.ph == PH_RUN));
        chk({t, "_running"},  64'(rn), 64'(m.ph == PH_RUN));
        chk({t, "_done"},     64'(dn), 64'(m.ph == PH_DONE));
        chk({t, "_pass"},     64'(ps), 64'(m.pass));
        chk({t, "_fail"},     64'(fl), 64'(m.fail));
        chk({t, "_timeout"},  64'(to), 64'(m.to));
        chk({t, "_exit"},     64'(ex), 64'(m.exitc));
        chk({t, "_cycles"},   cy,      64'(m.cyc));
        chk({t, "_instret"},  ic,      64'(m.ins));
    endtask

    task automatic compare_all();
        chk_inst("A", ma, a_core_rst, a_running, a_done, a_pass, a_fail, a_to, a_exit, 64'(a_cyc), 64'(a_ins));
        chk_inst("B", mb, b_core_rst, b_running, b_done, b_pass, b_fail, b_to, b_exit, 64'(b_cyc), 64'(b_ins));
        chk_inst("C", mc, c_core_rst, c_running, c_done, c_pass, c_fail, c_to, c_exit, 64'(c_cyc), 64'(c_ins));
    endtask

    // Advance one clock: model steps at the edge, outputs checked at the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            ma = mstep(ma, 3, 64, 32);
            mb = mstep(mb, 1, 16, 32);
            mc = mstep(mc, 2, 64, 4);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        ma = mreset();
        mb = mreset();
        mc = mreset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = mreset();
        mb = mreset();
        mc = mreset();
        #1 hard_reset();
        tick();
        tick();
        chk("lit_rst_core_rst", 64'(a_core_rst), 64'd0);
        chk("lit_rst_cycles",   64'(a_cyc),      64'd0);
        chk("lit_rst_done",     64'(a_done),     64'd0);
        rst_n = 1'b1;
        tick();

        // Start: core held in reset exactly three cycles, two retires ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("lit_hold_core_rst", 64'(a_core_rst), 64'd0);
            chk("lit_hold_running",  64'(a_running),  64'd0);
            ret = (k < 2);
            tick();
        end
        ret = 1'b0;
        chk("lit_run_core_rst", 64'(a_core_rst), 64'd1);
        chk("lit_run_running",  64'(a_running),  64'd1);

        // 10 retires, stray store to 0x1004 at cycle 5, pass store at cycle 20
        for (int r = 1; r <= 20; r++) begin
            we    = (r == 5 || r == 20);
            addr  = (r == 5) ? 32'h1004 : 32'h1000;
            wdata = 32'h1;
            ret   = (r <= 10);
            if (r == 10) chk("lit_stray_store_done", 64'(a_done), 64'd0);
            tick();
        end
        we = 1'b0;
        ret = 1'b0;
        chk("lit_pass_done",    64'(a_done),     64'd1);
        chk("lit_pass_pass",    64'(a_pass),     64'd1);
        chk("lit_pass_exit",    64'(a_exit),     64'd0);
        chk("lit_pass_cycles",  64'(a_cyc),      64'd20);
        chk("lit_pass_instret", 64'(a_ins),      64'd10);
        chk("lit_pass_core_rst",64'(a_core_rst), 64'd0);
        chk("lit_b_timeout",    64'(b_to),       64'd1);
        chk("lit_b_to_cycles",  64'(b_cyc),      64'd16);
        chk("lit_b_to_pass",    64'(b_pass),     64'd0);
        chk("lit_c_sat_cycles", 64'(c_cyc),      64'd15);
        chk("lit_c_instret",    64'(c_ins),      64'd10);

        // Restart from DONE, then fail store of 7 at RUN cycle 5
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lit_restart_cycles", 64'(a_cyc),  64'd0);
        chk("lit_restart_pass",   64'(a_pass), 64'd0);
        repeat (7) tick();
        we = 1'b1; addr = 32'h1000; wdata = 32'h7;
        tick();
        we = 1'b0;
        chk("lit_fail_fail",   64'(a_fail), 64'd1);
        chk("lit_fail_exit",   64'(a_exit), 64'd3);
        chk("lit_fail_cycles", 64'(a_cyc),  64'd5);

        // Store on B's 16th RUN cycle: tohost wins over timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        we = 1'b1; addr = 32'h1000; wdata = 32'h1;
        tick();
        we = 1'b0;
        chk("lit_b_tie_pass",    64'(b_pass), 64'd1);
        chk("lit_b_tie_timeout", 64'(b_to),   64'd0);
        chk("lit_b_tie_cycles",  64'(b_cyc),  64'd16);
        chk("lit_a_tie_cycles",  64'(a_cyc),  64'd14);

        // Abort beats start in DONE; counters held
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("lit_abort_done",   64'(a_done),    64'd0);
        chk("lit_abort_run",    64'(a_running), 64'd0);
        chk("lit_abort_pass",   64'(a_pass),    64'd0);
        chk("lit_abort_cycles", 64'(a_cyc),     64'd14);
        tick();

        // Asynchronous reset in the middle of RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        ret = 1'b1;
        repeat (6) tick();
        ret = 1'b0;
        hard_reset();
        #1;
        chk("lit_async_core_rst", 64'(a_core_rst), 64'd0);
        chk("lit_async_running",  64'(a_running),  64'd0);
        chk("lit_async_cycles",   64'(a_cyc),      64'd0);
        chk("lit_async_instret",  64'(a_ins),      64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) hard_reset();
            else rst_n = 1'b1;
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 99) == 0);
            we    = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0:       addr = 32'h1000;
                1:       addr = 32'h1004;
                default: addr = $urandom;
            endcase
            wdata = ($urandom_range(0, 2) == 0) ? 32'h1 : (($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255)));
            ret   = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
